pingpong_operand_buffer: RTL and testbench
==========================================

PINGPONG_OPERAND_BUFFER -- requirements
Module: pingpong_operand_buffer

Interface
REQ-001 Parameter WIDTH, default 32, data width of each bank; SHALL match the 32-bit operand width of mux32x2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 wr_valid  input  1  producer asserts: wr_data holds a valid operand.
REQ-005 wr_ready  output  1  buffer can accept a write this cycle.
REQ-006 wr_data  input  WIDTH  operand to store.
REQ-007 buf0_out  output  WIDTH  bank 0 contents; drives mux32x2 in0.
REQ-008 buf1_out  output  WIDTH  bank 1 contents; drives mux32x2 in1.
REQ-009 sel  output  1  read pointer; drives mux32x2 select (0 = bank 0, 1 = bank 1).
REQ-010 rd_valid  output  1  the bank addressed by sel holds an unconsumed operand.
REQ-011 rd_ready  input  1  consumer of the mux output accepts the current operand.
REQ-012 level  output  2  number of full banks (0, 1 or 2).

Function
REQ-013 The block SHALL be a two-entry ping-pong buffer: the write pointer (wptr) selects the bank to fill; sel selects the bank to drain.
REQ-014 Write handshake: a write SHALL occur on a rising edge with wr_valid=1 and wr_ready=1; it loads wr_data into bank[wptr], marks that bank full and toggles wptr.
REQ-015 Read handshake: a read SHALL occur on a rising edge with rd_valid=1 and rd_ready=1; it marks bank[sel] empty and toggles sel; bank data SHALL NOT be cleared.
REQ-016 State machine: states EMPTY (level 0), HALF (level 1), FULL (level 2).
REQ-017 EMPTY: write -> HALF; an rd_ready without a write is ignored.
REQ-018 HALF: write only -> FULL; read only -> EMPTY; simultaneous write and read -> HALF, with both pointers toggled.
REQ-019 FULL: read -> HALF; a wr_valid without wr_ready is held off, not dropped, and no state changes.
REQ-020 wr_ready SHALL be 1 in EMPTY and HALF and 0 in FULL; it SHALL depend only on the registered state.
REQ-021 rd_valid SHALL be 1 in HALF and FULL and 0 in EMPTY; it SHALL depend only on the registered state.
REQ-022 There SHALL be no write-to-read bypass: a written operand first appears on rd_valid and bufN_out one cycle after the write edge, so latency is 1 cycle.
REQ-023 Pointers SHALL wrap 1 -> 0 on toggle; the order of operands presented at the mux output SHALL equal the write order.
REQ-024 bufN_out, sel, level, wr_ready and rd_valid SHALL be driven directly from registers or the state decode, with no combinational path from any input.
REQ-025 wr_data SHALL NOT be written into a full bank under any input combination.

Reset
REQ-026 While reset_n=0, and immediately on its falling edge: state=EMPTY, wptr=0, sel=0, buf0_out=0, buf1_out=0, level=0, wr_ready=1, rd_valid=0.
REQ-027 Reset asserted mid-transfer SHALL discard all stored operands; no handshake SHALL complete on the edge at which reset_n is low.
REQ-028 The first rising edge after reset_n deasserts SHALL behave as a normal cycle.

Structure
REQ-029 A shared package pp_buffer_pkg SHALL hold WIDTH, the state enumeration (EMPTY, HALF, FULL) and level constants.
REQ-030 One sub-module, pp_bank, SHALL be used: a WIDTH register with a load enable, a full flag and an asynchronous clear, instantiated twice.
REQ-031 mux32x2 SHALL remain external; the bench SHALL connect buf0_out, buf1_out and sel to it and check the mux output.

Verification
REQ-032 Reset: drive reset_n=0 with random inputs -> all outputs at their REQ-026 values; release -> wr_ready=1, rd_valid=0.
REQ-033 Fill then drain: write FFFFFFFF then 01234567 with rd_ready=0 -> level=2, wr_ready=0; then rd_ready=1 for 2 cycles -> mux output FFFFFFFF then 01234567, sel 0 -> 1 -> 0, level back to 0.
REQ-034 Full backpressure: in FULL, hold wr_valid=1 with wr_data=BBBB0000 -> both banks unchanged; after one read, the write completes into the freed bank on the next edge.
REQ-035 Simultaneous read and write in HALF: bank0=ABCDEF00, write 12345678 with rd_ready=1 -> mux outputs ABCDEF00 then 12345678, level stays 1, wrap-around correct.
REQ-036 Empty read: rd_ready=1 with level=0 for 3 cycles -> sel and level unchanged, rd_valid=0.
REQ-037 Mid-operation reset: in FULL, pulse reset_n low between clock edges -> outputs clear asynchronously, and the next write lands in bank 0.

Source files
------------

// File: rtl/pp_buffer_pkg.sv
// Shared definitions for the ping-pong operand buffer: data width,
// occupancy state encoding and the matching level constants.
package pp_buffer_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] LEVEL_EMPTY = 2'd0;
  localparam logic [1:0] LEVEL_HALF  = 2'd1;
  localparam logic [1:0] LEVEL_FULL  = 2'd2;

  // Number of full banks implied by an occupancy state.
  function automatic logic [1:0] level_of(input state_t s);
    case (s)
      HALF:    level_of = LEVEL_HALF;
      FULL:    level_of = LEVEL_FULL;
      default: level_of = LEVEL_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/mux32x2.sv
// Existing 2:1 operand multiplexer that sits downstream of the buffer.
module mux32x2 (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        sel,
  output logic [31:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/pp_bank.sv
// One storage bank: a data register with load enable and a full flag.
// Reading only clears the flag; the stored data stays visible.
module pp_bank
  import pp_buffer_pkg::*;
#(
  parameter int BANK_WIDTH = WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  consume,
  input  logic [BANK_WIDTH-1:0] data_in,
  output logic [BANK_WIDTH-1:0] data_out,
  output logic                  full
);

  // Capture the operand on load; reset wipes any stored operand.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= data_in;
    end
  end

  // Occupancy flag: a load fills the bank, a consume empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (consume) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pingpong_operand_buffer.sv
// Two-entry ping-pong operand buffer. The write pointer picks the bank to
// fill, sel picks the bank the external mux presents. All handshake outputs
// decode from registered state only, so there is no input-to-output path.
module pingpong_operand_buffer
  import pp_buffer_pkg::*;
#(
  parameter int WIDTH = pp_buffer_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] buf0_out,
  output logic [WIDTH-1:0] buf1_out,
  output logic             sel,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [1:0]       level
);

  state_t state_q, state_d;
  logic   wptr_q, wptr_d;
  logic   sel_q, sel_d;
  logic   wr_fire, rd_fire;
  logic   bank0_full, bank1_full;
  logic   load0, load1, consume0, consume1;

  assign wr_ready = (state_q != FULL);
  assign rd_valid = (state_q != EMPTY);
  assign level    = level_of(state_q);
  assign sel      = sel_q;

  assign wr_fire = wr_valid && wr_ready;
  assign rd_fire = rd_valid && rd_ready;

  // The bank full flag is a second guard so a full bank is never overwritten.
  assign load0    = wr_fire && (wptr_q == 1'b0) && !bank0_full;
  assign load1    = wr_fire && (wptr_q == 1'b1) && !bank1_full;
  assign consume0 = rd_fire && (sel_q == 1'b0);
  assign consume1 = rd_fire && (sel_q == 1'b1);

  pp_bank #(.BANK_WIDTH(WIDTH)) u_bank0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load0),
    .consume  (consume0),
    .data_in  (wr_data),
    .data_out (buf0_out),
    .full     (bank0_full)
  );

  pp_bank #(.BANK_WIDTH(WIDTH)) u_bank1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load1),
    .consume  (consume1),
    .data_in  (wr_data),
    .data_out (buf1_out),
    .full     (bank1_full)
  );

  // State and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      wptr_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      sel_q   <= sel_d;
    end
  end

  // Occupancy transitions; each completed handshake toggles its pointer.
  always_comb begin
    state_d = state_q;
    wptr_d  = wr_fire ? ~wptr_q : wptr_q;
    sel_d   = rd_fire ? ~sel_q : sel_q;
    case (state_q)
      EMPTY: begin
        if (wr_fire) state_d = HALF;
      end
      HALF: begin
        case ({wr_fire, rd_fire})
          2'b10:   state_d = FULL;
          2'b01:   state_d = EMPTY;
          default: state_d = HALF;
        endcase
      end
      FULL: begin
        if (rd_fire) state_d = HALF;
      end
      default: begin
        state_d = EMPTY;
        wptr_d  = 1'b0;
        sel_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pingpong_operand_buffer.sv
// Directed bench for the ping-pong operand buffer driving the external mux.
module tb_pingpong_operand_buffer;

  logic        clk;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [31:0] buf0_out;
  logic [31:0] buf1_out;
  logic        sel;
  logic        rd_valid;
  logic        rd_ready;
  logic [1:0]  level;
  logic [31:0] mux_y;

  int vectors;
  int miscompares;

  pingpong_operand_buffer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .buf0_out (buf0_out),
    .buf1_out (buf1_out),
    .sel      (sel),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .level    (level)
  );

  mux32x2 u_mux (
    .in0 (buf0_out),
    .in1 (buf1_out),
    .sel (sel),
    .y   (mux_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic apply_stimulus(input logic wv, input logic [31:0] wd,
                                input logic rr);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check_output({tag, "_buf0"},     buf0_out,       32'h0);
    check_output({tag, "_buf1"},     buf1_out,       32'h0);
    check_output({tag, "_sel"},      {31'h0, sel},   32'h0);
    check_output({tag, "_level"},    {30'h0, level}, 32'h0);
    check_output({tag, "_wr_ready"}, {31'h0, wr_ready}, 32'h1);
    check_output({tag, "_rd_valid"}, {31'h0, rd_valid}, 32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b1;
    apply_stimulus(1'b1, $urandom, 1'b1);
    #1 reset_n = 1'b0;

    // Reset held with random activity on the inputs.
    tick();
    apply_stimulus(1'b1, $urandom, 1'b1);
    tick();
    check_idle_reset("reset");
    apply_stimulus(1'b0, 32'h0, 1'b0);
    reset_n = 1'b1;
    tick();
    check_output("release_wr_ready", {31'h0, wr_ready}, 32'h1);
    check_output("release_rd_valid", {31'h0, rd_valid}, 32'h0);

    // Fill both banks without reading.
    apply_stimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
    tick();
    check_output("fill1_level", {30'h0, level}, 32'd1);
    check_output("fill1_mux",   mux_y,          32'hFFFF_FFFF);
    check_output("fill1_rd_valid", {31'h0, rd_valid}, 32'h1);
    apply_stimulus(1'b1, 32'h0123_4567, 1'b0);
    tick();
    check_output("fill2_level",    {30'h0, level},    32'd2);
    check_output("fill2_wr_ready", {31'h0, wr_ready}, 32'h0);
    check_output("fill2_buf1",     buf1_out,          32'h0123_4567);

    // Drain in write order.
    apply_stimulus(1'b0, 32'h0, 1'b1);
    check_output("drain0_mux", mux_y, 32'hFFFF_FFFF);
    check_output("drain0_sel", {31'h0, sel}, 32'h0);
    tick();
    check_output("drain1_mux",   mux_y,          32'h0123_4567);
    check_output("drain1_sel",   {31'h0, sel},   32'h1);
    check_output("drain1_level", {30'h0, level}, 32'd1);
    tick();
    check_output("drain2_sel",      {31'h0, sel},      32'h0);
    check_output("drain2_level",    {30'h0, level},    32'd0);
    check_output("drain2_rd_valid", {31'h0, rd_valid}, 32'h0);

    // Reads while empty are ignored.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("empty_rd_sel",      {31'h0, sel},      32'h0);
      check_output("empty_rd_level",    {30'h0, level},    32'd0);
      check_output("empty_rd_rd_valid", {31'h0, rd_valid}, 32'h0);
    end

    // Fill again, then hold a write off while full.
    apply_stimulus(1'b1, 32'hAAAA_1111, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h2222_3333, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'hBBBB_0000, 1'b0);
    tick();
    tick();
    check_output("bp_buf0",  buf0_out,       32'hAAAA_1111);
    check_output("bp_buf1",  buf1_out,       32'h2222_3333);
    check_output("bp_level", {30'h0, level}, 32'd2);
    apply_stimulus(1'b1, 32'hBBBB_0000, 1'b1);
    tick();
    check_output("bp_read_buf0",  buf0_out,       32'hAAAA_1111);
    check_output("bp_read_sel",   {31'h0, sel},   32'h1);
    check_output("bp_read_level", {30'h0, level}, 32'd1);
    apply_stimulus(1'b1, 32'hBBBB_0000, 1'b0);
    tick();
    check_output("bp_write_buf0",  buf0_out,       32'hBBBB_0000);
    check_output("bp_write_buf1",  buf1_out,       32'h2222_3333);
    check_output("bp_write_level", {30'h0, level}, 32'd2);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    check_output("bp_drain0_mux", mux_y, 32'h2222_3333);
    tick();
    check_output("bp_drain1_mux", mux_y, 32'hBBBB_0000);
    tick();
    check_output("bp_drain_level", {30'h0, level}, 32'd0);
    check_output("bp_drain_sel",   {31'h0, sel},   32'h1);

    // Fill (bank1 then bank0) and reset between clock edges.
    apply_stimulus(1'b1, 32'h1111_0000, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h2222_0000, 1'b0);
    tick();
    check_output("pre_rst_level", {30'h0, level}, 32'd2);
    apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check_idle_reset("async_rst");
    tick();
    check_idle_reset("rst_edge");
    reset_n = 1'b1;
    apply_stimulus(1'b1, 32'hABCD_EF00, 1'b0);
    tick();
    check_output("post_rst_buf0",  buf0_out,       32'hABCD_EF00);
    check_output("post_rst_buf1",  buf1_out,       32'h0);
    check_output("post_rst_level", {30'h0, level}, 32'd1);

    // Simultaneous write and read while half full.
    apply_stimulus(1'b1, 32'h1234_5678, 1'b1);
    check_output("simul0_mux", mux_y, 32'hABCD_EF00);
    tick();
    check_output("simul1_mux",   mux_y,          32'h1234_5678);
    check_output("simul1_level", {30'h0, level}, 32'd1);
    check_output("simul1_sel",   {31'h0, sel},   32'h1);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    tick();
    check_output("wrap_sel",   {31'h0, sel},   32'h0);
    check_output("wrap_level", {30'h0, level}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #20000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
